// File: rtl/wav_pkg.sv
// Shared definitions for the WAV sample reader: FSM state encoding, frames-per-word
// constants and the 8-bit unsigned-to-signed offset.
package wav_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_FETCH = 2'd0;
    localparam state_t ST_LATCH = 2'd1;
    localparam state_t ST_EMIT  = 2'd2;

    localparam logic [2:0] FPW_16_STEREO = 3'd1;
    localparam logic [2:0] FPW_16_MONO   = 3'd2;
    localparam logic [2:0] FPW_8_STEREO  = 3'd2;
    localparam logic [2:0] FPW_8_MONO    = 3'd4;

    localparam logic [7:0] PCM8_OFFSET = 8'h80;

    function automatic logic [2:0] frames_per_word(input logic bits16, input logic stereo);
        logic [2:0] n;
        case ({bits16, stereo})
            2'b11:   n = FPW_16_STEREO;
            2'b10:   n = FPW_16_MONO;
            2'b01:   n = FPW_8_STEREO;
            default: n = FPW_8_MONO;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/wav_frame_select.sv
// Combinational frame decoder: picks the left/right samples of one frame out of a
// FIFO word, given the frame index and the PCM format of that word.
module wav_frame_select
    import wav_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic [WORD_W-1:0]   word,
    input  logic [1:0]          frame_idx,
    input  logic                bits16,
    input  logic                stereo,
    output logic [SAMPLE_W-1:0] left,
    output logic [SAMPLE_W-1:0] right
);

    logic [7:0]  bytes_s [4];
    logic [15:0] s16_s   [2];
    logic [15:0] s8_s    [4];
    logic [15:0] left16_s;
    logic [15:0] right16_s;

    // Byte 0 is the oldest byte in the FIFO, taken from the top of the word.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bytes_s[k] = word[WORD_W-1-8*k -: 8];
        end
    end

    // Candidate samples: little-endian 16-bit pairs and re-centred 8-bit bytes.
    always_comb begin
        s16_s[0] = {bytes_s[1], bytes_s[0]};
        s16_s[1] = {bytes_s[3], bytes_s[2]};
        for (int k = 0; k < 4; k++) begin
            s8_s[k] = {bytes_s[k] ^ PCM8_OFFSET, 8'h00};
        end
    end

    // Frame multiplexer; mono frames duplicate the single sample on both channels.
    always_comb begin
        left16_s  = 16'h0000;
        right16_s = 16'h0000;
        case ({bits16, stereo})
            2'b11: begin
                left16_s  = s16_s[0];
                right16_s = s16_s[1];
            end
            2'b10: begin
                left16_s  = s16_s[frame_idx[0]];
                right16_s = s16_s[frame_idx[0]];
            end
            2'b01: begin
                left16_s  = s8_s[{frame_idx[0], 1'b0}];
                right16_s = s8_s[{frame_idx[0], 1'b1}];
            end
            default: begin
                left16_s  = s8_s[frame_idx];
                right16_s = s8_s[frame_idx];
            end
        endcase
    end

    assign left  = SAMPLE_W'(left16_s);
    assign right = SAMPLE_W'(right16_s);

endmodule

// File: rtl/wav_sample_reader.sv
// Reads packed PCM words from an audio FIFO and emits one stereo frame per handshake.
// Three-state FSM: FETCH issues the read, LATCH captures the word, EMIT drains its frames.
module wav_sample_reader
    import wav_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cfg_bits16,
    input  logic                cfg_stereo,
    input  logic                fifo_empty,
    input  logic [WORD_W-1:0]   fifo_dout,
    output logic                fifo_rd_en,
    output logic [SAMPLE_W-1:0] sample_left,
    output logic [SAMPLE_W-1:0] sample_right,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                underrun,
    output logic [31:0]         frame_count
);

    state_t              state_r;
    logic [1:0]          idx_r;
    logic [WORD_W-1:0]   word_r;
    logic                bits16_r;
    logic                stereo_r;
    logic [SAMPLE_W-1:0] left_r;
    logic [SAMPLE_W-1:0] right_r;
    logic                valid_r;
    logic                underrun_r;
    logic [31:0]         frame_count_r;

    logic [WORD_W-1:0]   sel_word_s;
    logic [1:0]          sel_idx_s;
    logic                sel_bits16_s;
    logic                sel_stereo_s;
    logic [SAMPLE_W-1:0] sel_left_s;
    logic [SAMPLE_W-1:0] sel_right_s;
    logic                last_s;
    logic                handshake_s;

    // In LATCH the decoder looks straight at the FIFO so frame 0 is registered on entry
    // to EMIT; in EMIT it looks one frame ahead so the next frame follows a handshake.
    always_comb begin
        if (state_r == ST_LATCH) begin
            sel_word_s   = fifo_dout;
            sel_idx_s    = 2'd0;
            sel_bits16_s = cfg_bits16;
            sel_stereo_s = cfg_stereo;
        end else begin
            sel_word_s   = word_r;
            sel_idx_s    = idx_r + 2'd1;
            sel_bits16_s = bits16_r;
            sel_stereo_s = stereo_r;
        end
    end

    wav_frame_select #(
        .WORD_W   (WORD_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_frame_select (
        .word      (sel_word_s),
        .frame_idx (sel_idx_s),
        .bits16    (sel_bits16_s),
        .stereo    (sel_stereo_s),
        .left      (sel_left_s),
        .right     (sel_right_s)
    );

    assign last_s      = ({1'b0, idx_r} == (frames_per_word(bits16_r, stereo_r) - 3'd1));
    assign handshake_s = valid_r & sample_ready;
    assign fifo_rd_en  = ~rst & (state_r == ST_FETCH) & enable & ~fifo_empty;

    // FSM, word/format capture, output registers and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_FETCH;
            idx_r         <= 2'd0;
            word_r        <= '0;
            bits16_r      <= 1'b0;
            stereo_r      <= 1'b0;
            left_r        <= '0;
            right_r       <= '0;
            valid_r       <= 1'b0;
            underrun_r    <= 1'b0;
            frame_count_r <= 32'd0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (enable && !fifo_empty) begin
                        state_r <= ST_LATCH;
                    end else if (enable) begin
                        underrun_r <= 1'b1;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_LATCH: begin
                    word_r   <= fifo_dout;
                    bits16_r <= cfg_bits16;
                    stereo_r <= cfg_stereo;
                    idx_r    <= 2'd0;
                    left_r   <= sel_left_s;
                    right_r  <= sel_right_s;
                    valid_r  <= 1'b1;
                    state_r  <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (handshake_s) begin
                        frame_count_r <= frame_count_r + 32'd1;
                        if (last_s) begin
                            valid_r <= 1'b0;
                            state_r <= ST_FETCH;
                        end else begin
                            idx_r   <= idx_r + 2'd1;
                            left_r  <= sel_left_s;
                            right_r <= sel_right_s;
                        end
                    end else begin
                        state_r <= ST_EMIT;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    assign sample_left  = left_r;
    assign sample_right = right_r;
    assign sample_valid = valid_r;
    assign underrun     = underrun_r;
    assign frame_count  = frame_count_r;

endmodule

// File: tb/tb_wav_sample_reader.sv
// Scoreboard bench for wav_sample_reader: a FIFO model feeds words, a reference model
// expands each word into expected frames, and a monitor checks every handshake.
module tb_wav_sample_reader;

    typedef struct {
        logic [31:0] w;
        logic        b16;
        logic        st;
    } stim_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        cfg_bits16;
    logic        cfg_stereo;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        underrun;
    logic [31:0] frame_count;

    stim_t  stim_q [$];
    frame_t exp_q  [$];
    logic [31:0] exp_fc;
    int checks;
    int errors;

    logic nxt_rst, nxt_en, nxt_rdy, cfg_noise, rd_seen;

    wav_sample_reader #(.WORD_W(32), .SAMPLE_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_bits16   (cfg_bits16),
        .cfg_stereo   (cfg_stereo),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun     (underrun),
        .frame_count  (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, want);
        end
    endtask

    // Reference model: split the word into bytes (oldest first), build samples, pair them.
    function automatic void expand(input logic [31:0] w, input logic b16, input logic st);
        logic [7:0]  b [4];
        logic [15:0] s [4];
        int n;
        frame_t f;
        for (int k = 0; k < 4; k++) b[k] = w[31-8*k -: 8];
        if (b16) begin
            s[0] = {b[1], b[0]};
            s[1] = {b[3], b[2]};
            s[2] = 16'h0000;
            s[3] = 16'h0000;
            n = 2;
        end else begin
            for (int k = 0; k < 4; k++) s[k] = {b[k] ^ 8'h80, 8'h00};
            n = 4;
        end
        if (st) begin
            for (int j = 0; j < n / 2; j++) begin
                f.l = s[2*j];
                f.r = s[2*j+1];
                exp_q.push_back(f);
            end
        end else begin
            for (int j = 0; j < n; j++) begin
                f.l = s[j];
                f.r = s[j];
                exp_q.push_back(f);
            end
        end
    endfunction

    // Drive phase just after the rising edge, observe phase on the falling edge.
    task automatic tick();
        stim_t e;
        @(posedge clk);
        #1;
        rst          = nxt_rst;
        enable       = nxt_en;
        sample_ready = nxt_rdy;
        if (nxt_rst) begin
            exp_q.delete();
            exp_fc = 32'd0;
        end
        if (rd_seen) begin
            if (stim_q.size() == 0) begin
                chk("spurious_rd", 32'd1, 32'd0);
                fifo_dout = $urandom;
            end else begin
                e = stim_q.pop_front();
                fifo_dout  = e.w;
                cfg_bits16 = e.b16;
                cfg_stereo = e.st;
                expand(e.w, e.b16, e.st);
            end
        end else begin
            fifo_dout = $urandom;
            if (cfg_noise) begin
                cfg_bits16 = 1'($urandom_range(0, 1));
                cfg_stereo = 1'($urandom_range(0, 1));
            end
        end
        fifo_empty = (stim_q.size() == 0);
        @(negedge clk);
        rd_seen = fifo_rd_en;
    endtask

    task automatic monitor();
        logic stall;
        logic [15:0] pl, pr;
        frame_t f;
        stall = 1'b0;
        pl = 16'h0000;
        pr = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", {31'd0, sample_valid}, 32'd1);
                    chk("hold_data", {sample_left, sample_right}, {pl, pr});
                end
                if (sample_valid) begin
                    chk("no_rd_in_emit", {31'd0, fifo_rd_en}, 32'd0);
                    if (sample_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", {sample_left, sample_right}, 32'd0);
                            chk("unexpected_frame_flag", 32'd1, 32'd0);
                        end else begin
                            f = exp_q.pop_front();
                            chk("frame", {sample_left, sample_right}, {f.l, f.r});
                        end
                        chk("frame_count", frame_count, exp_fc);
                        exp_fc = exp_fc + 32'd1;
                    end
                end
                stall = sample_valid & ~sample_ready;
                pl = sample_left;
                pr = sample_right;
            end
        end
    endtask

    task automatic push(input logic [31:0] w, input logic b16, input logic st);
        stim_t e;
        e.w = w;
        e.b16 = b16;
        e.st = st;
        stim_q.push_back(e);
    endtask

    task automatic drain(input string name, input int bound, input logic rnd);
        int n;
        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0 || sample_valid) && n < bound) begin
            if (rnd) begin
                nxt_rdy = ($urandom_range(0, 3) != 0);
                nxt_en  = ($urandom_range(0, 7) != 0);
            end
            tick();
            n++;
        end
        if (n >= bound) chk({name, "_timeout"}, 32'd1, 32'd0);
        nxt_rdy = 1'b1;
        nxt_en  = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int bound);
        int n;
        n = 0;
        while (!sample_valid && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_fc = 32'd0;
        rst = 1'b1;
        enable = 1'b0;
        cfg_bits16 = 1'b0;
        cfg_stereo = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout = 32'd0;
        sample_ready = 1'b0;
        nxt_rst = 1'b1;
        nxt_en = 1'b0;
        nxt_rdy = 1'b0;
        cfg_noise = 1'b0;
        rd_seen = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) tick();
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_samples", {sample_left, sample_right}, 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);

        nxt_rst = 1'b0;
        repeat (3) tick();
        chk("idle_underrun", {31'd0, underrun}, 32'd0);
        chk("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);

        nxt_en = 1'b1;
        repeat (3) tick();
        chk("underrun_set", {31'd0, underrun}, 32'd1);
        chk("empty_rd_en", {31'd0, fifo_rd_en}, 32'd0);

        // Directed format examples.
        nxt_rdy = 1'b1;
        push(32'h34127856, 1'b1, 1'b1);
        push(32'h34127856, 1'b1, 1'b0);
        push(32'h80FF0001, 1'b0, 1'b0);
        drain("directed", 200, 1'b0);
        chk("directed_count", frame_count, 32'd7);

        // Backpressure on frame 0 of an 8-bit stereo word.
        nxt_rdy = 1'b0;
        push($urandom, 1'b0, 1'b1);
        wait_valid("bp_start", 50);
        repeat (5) tick();
        chk("bp_still_valid", {31'd0, sample_valid}, 32'd1);
        nxt_rdy = 1'b1;
        drain("bp", 100, 1'b0);

        // Randomized traffic with backpressure, enable gaps and cfg noise during EMIT.
        cfg_noise = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain("random", 3000, 1'b1);
        chk("underrun_sticky", {31'd0, underrun}, 32'd1);

        // Reset while frame 1 of an 8-bit mono word is on the outputs.
        cfg_noise = 1'b0;
        nxt_rdy = 1'b1;
        push($urandom, 1'b0, 1'b0);
        push($urandom, 1'b1, 1'b0);
        push($urandom, 1'b0, 1'b1);
        wait_valid("mid_start", 50);
        nxt_rdy = 1'b0;
        tick();
        chk("mid_frame1_valid", {31'd0, sample_valid}, 32'd1);
        nxt_rst = 1'b1;
        tick();
        chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("mid_rst_underrun", {31'd0, underrun}, 32'd0);
        chk("mid_rst_samples", {sample_left, sample_right}, 32'd0);
        chk("mid_rst_frame_count", frame_count, 32'd0);
        nxt_rst = 1'b0;
        nxt_rdy = 1'b1;
        drain("post_rst", 200, 1'b0);
        chk("post_rst_count", frame_count, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
